online_conv_ctrl: RTL and testbench
===================================

ONLINE_CONV_CTRL -- requirements
Module: online_conv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, number of result digits converted per operation (>=2).
REQ-002 SHALL have parameter DELTA, default 2, online delay in cycles between start acceptance and the first converted digit (>=0).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a new conversion.
REQ-006 abort  input  1  cancel the current operation.
REQ-007 in_valid  input  1  in_digit carries a valid MSDF digit.
REQ-008 in_digit  input  signed_digit  redundant digit {plus, minus}.
REQ-009 in_ready  output  1  controller accepts in_digit this cycle.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 res_valid  output  1  res_plus/res_minus hold a completed result.
REQ-012 res_ready  input  1  consumer takes the result.
REQ-013 res_plus  output  WIDTH  converted value Q (MSB = weight 2^-1).
REQ-014 res_minus  output  WIDTH  companion value QM = Q - ulp.

Function
REQ-015 States SHALL be IDLE, DELAY, CONVERT, DONE.
REQ-016 IDLE: start=1 SHALL clear the converter and go to DELAY, or to CONVERT directly when DELTA=0.
REQ-017 DELAY: in_ready SHALL be 0; a cycle counter SHALL go to CONVERT after exactly DELTA cycles in DELAY.
REQ-018 CONVERT: in_ready SHALL be 1; each cycle with in_valid&&in_ready SHALL enable the converter for exactly one digit and increment a digit counter of width $clog2(WIDTH+1).
REQ-019 in_valid=0 in CONVERT SHALL stall: converter not enabled, counter held.
REQ-020 The WIDTH-th accepted digit SHALL move the FSM to DONE on the following edge; in_ready SHALL be 0 from that edge.
REQ-021 DONE: res_valid SHALL be 1 and res_plus/res_minus SHALL be stable until res_valid&&res_ready.
REQ-022 DONE with res_ready=1 and start=0 SHALL return to IDLE; with res_ready=1 and start=1 SHALL clear the converter and enter DELAY (back-to-back).
REQ-023 start SHALL be ignored in DELAY, CONVERT, and DONE without res_ready.
REQ-024 Digit encodings {0,0} and {1,1} SHALL both be converted as zero.
REQ-025 abort=1 SHALL, in any state, clear the converter and go to IDLE on the next edge; abort SHALL take priority over start, in_valid and res_ready in the same cycle.
REQ-026 Converter clear SHALL be a one-cycle synchronous clear driven on the edge that accepts start or abort, so res_plus/res_minus read 0 in the first cycle of DELAY/CONVERT.
REQ-027 res_plus/res_minus SHALL be the live converter outputs (no extra register); they are meaningful only while res_valid=1.

Reset
REQ-028 rst=1 SHALL force IDLE, clear both counters and the converter; in_ready=0, busy=0, res_valid=0, res_plus=0, res_minus=0 in the cycle after.
REQ-029 rst SHALL take priority over abort and start; reset mid-operation SHALL discard partial results.

Structure
REQ-030 signed_digit typedef and the FSM state enum SHALL live in rbr_pkg.
REQ-031 The conversion datapath SHALL be the existing on-the-fly converter ca_reg (one instance), driven by the controller's enable and an active-low clear derived from rst|clear.

Verification (WIDTH=8, DELTA=2)
REQ-032 Reset: rst 1 cycle -> all outputs 0, busy=0.
REQ-033 start; digits +1,0,0,0,0,0,0,0 continuous -> in_ready rises 2 cycles after start, res_valid after 8th digit, res_plus=8'h80, res_minus=8'h7F.
REQ-034 start; digits +1,-1,0,0,0,0,0,0 with in_valid low 3 cycles after digit 4 -> stall honoured, res_plus=8'h40, res_minus=8'h3F.
REQ-035 abort asserted during 5th digit, together with start -> IDLE next cycle, res_valid=0; new run of +1,0..0 yields 8'h80.
REQ-036 DONE with res_ready=1 and start=1 same cycle -> DELAY entered, res_plus=0 next cycle, second result correct.
REQ-037 rst asserted in CONVERT after 3 digits -> IDLE, outputs 0; start in DONE without res_ready -> ignored, result held.

Source files
------------

// File: rtl/rbr_pkg.sv
// Shared types for the redundant-binary (MSDF) datapath: the signed-digit
// encoding and the controller's state encoding.
package rbr_pkg;

  typedef struct packed {
    logic plus;
    logic minus;
  } signed_digit;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    CONVERT,
    DONE
  } conv_state_t;

  // {0,0} and {1,1} both decode as zero, so only the asymmetric codes matter
  function automatic logic digit_is_pos(signed_digit d);
    return d.plus & ~d.minus;
  endfunction

  function automatic logic digit_is_neg(signed_digit d);
    return d.minus & ~d.plus;
  endfunction

endpackage

// File: rtl/ca_reg.sv
// On-the-fly converter: turns an MSDF signed-digit stream into the
// conventional value Q and its companion QM = Q - ulp, one digit per enable.
module ca_reg
  import rbr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  signed_digit      digit,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qm
);

  // A negative digit borrows by appending to QM; the other cases extend Q
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q  <= '0;
      qm <= '0;
    end else if (en) begin
      if (digit_is_pos(digit)) begin
        q  <= {q[WIDTH-2:0], 1'b1};
        qm <= {q[WIDTH-2:0], 1'b0};
      end else if (digit_is_neg(digit)) begin
        q  <= {qm[WIDTH-2:0], 1'b1};
        qm <= {qm[WIDTH-2:0], 1'b0};
      end else begin
        q  <= {q[WIDTH-2:0], 1'b0};
        qm <= {qm[WIDTH-2:0], 1'b1};
      end
    end
  end

endmodule

// File: rtl/online_conv_ctrl.sv
// Controller sequencing one online conversion: waits out the online delay,
// feeds WIDTH digits into the on-the-fly converter and holds the result.
module online_conv_ctrl
  import rbr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DELTA = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  signed_digit      in_digit,
  output logic             in_ready,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_plus,
  output logic [WIDTH-1:0] res_minus
);

  localparam int DGW = $clog2(WIDTH + 1);
  localparam int DCW = (DELTA > 1) ? $clog2(DELTA) : 1;
  localparam conv_state_t FIRST_STATE = (DELTA == 0) ? CONVERT : DELAY;

  conv_state_t    state, state_next;
  logic [DCW-1:0] dly_cnt;
  logic [DGW-1:0] dig_cnt;
  logic           accept, clear, dly_last, dig_last;

  assign dly_last = (int'(dly_cnt) >= DELTA - 1);
  assign dig_last = (dig_cnt == DGW'(WIDTH - 1));

  // abort outranks every other request; clear fires on the accepting edge
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    accept     = 1'b0;
    if (abort) begin
      state_next = IDLE;
      clear      = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            clear      = 1'b1;
            state_next = FIRST_STATE;
          end
        end
        DELAY: begin
          if (dly_last) state_next = CONVERT;
        end
        CONVERT: begin
          if (in_valid) begin
            accept = 1'b1;
            if (dig_last) state_next = DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            if (start) begin
              clear      = 1'b1;
              state_next = FIRST_STATE;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Counters restart from zero each time their state is (re)entered
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dly_cnt <= '0;
      dig_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == DELAY && state_next == DELAY) dly_cnt <= dly_cnt + DCW'(1);
      else                                       dly_cnt <= '0;
      if (state_next != CONVERT) dig_cnt <= '0;
      else if (accept)           dig_cnt <= dig_cnt + DGW'(1);
    end
  end

  assign in_ready  = (state == CONVERT);
  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);

  ca_reg #(
    .WIDTH(WIDTH)
  ) u_ca_reg (
    .clk  (clk),
    .clr_n(~(rst | clear)),
    .en   (accept),
    .digit(in_digit),
    .q    (res_plus),
    .qm   (res_minus)
  );

endmodule

// File: tb/tb_online_conv_ctrl.sv
// Scoreboard bench for online_conv_ctrl (WIDTH=8, DELTA=2): expected results
// come from an arithmetic model of the digit stream, not from the converter.
module tb_online_conv_ctrl;
  import rbr_pkg::*;

  localparam int WIDTH = 8;
  localparam int DELTA = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  signed_digit      in_digit = '0;
  logic             in_ready;
  logic             busy;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [WIDTH-1:0] res_plus;
  logic [WIDTH-1:0] res_minus;

  int total = 0;
  int bad = 0;
  int digs[8];
  logic [15:0] exp_q[$];
  logic [7:0] last_plus, last_minus;

  online_conv_ctrl #(
    .WIDTH(WIDTH),
    .DELTA(DELTA)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_digit (in_digit),
    .in_ready (in_ready),
    .busy     (busy),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_plus (res_plus),
    .res_minus(res_minus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  // Q = sum d_i * 2^-i expressed in ulps; QM is one ulp below
  function automatic logic [15:0] modelResult();
    int acc = 0;
    for (int i = 0; i < 8; i++) acc += digs[i] * (1 << (7 - i));
    return {acc[7:0], 8'(acc - 1)};
  endfunction

  function automatic signed_digit encode(input int d, input logic zero11);
    signed_digit s;
    if (d > 0)       s = '{plus: 1'b1, minus: 1'b0};
    else if (d < 0)  s = '{plus: 1'b0, minus: 1'b1};
    else if (zero11) s = '{plus: 1'b1, minus: 1'b1};
    else             s = '{plus: 1'b0, minus: 1'b0};
    return s;
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
    checkOutput({tag, "_res_valid"}, 32'(res_valid), 0);
    checkOutput({tag, "_res_plus"}, 32'(res_plus), 0);
    checkOutput({tag, "_res_minus"}, 32'(res_minus), 0);
  endtask

  task automatic waitInReady(input string tag);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) checkOutput({tag, "_ready_timeout"}, 0, 1);
  endtask

  task automatic startRun(input logic check_timing);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (check_timing) begin
      checkOutput("delay1_busy", 32'(busy), 1);
      checkOutput("delay1_in_ready", 32'(in_ready), 0);
      checkOutput("delay1_res_plus", 32'(res_plus), 0);
      tick();
      checkOutput("delay2_in_ready", 32'(in_ready), 0);
      tick();
      checkOutput("convert_in_ready", 32'(in_ready), 1);
    end
  endtask

  // Drives the first n digits of digs; a full run pushes its expected result
  task automatic applyStimulus(input int n, input int stall_after, input int stall_len,
                               input logic zero11);
    waitInReady("feed");
    for (int i = 0; i < n; i++) begin
      if (i == stall_after) begin
        in_valid = 1'b0;
        repeat (stall_len) tick();
        checkOutput("stall_in_ready", 32'(in_ready), 1);
        checkOutput("stall_res_valid", 32'(res_valid), 0);
      end
      in_digit = encode(digs[i], zero11);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_digit = '0;
    if (n == 8) exp_q.push_back(modelResult());
  endtask

  task automatic waitResult(input string tag);
    int n = 0;
    logic [15:0] e;
    while (!res_valid && n < 40) begin
      tick();
      n++;
    end
    if (!res_valid) begin
      checkOutput({tag, "_valid_timeout"}, 0, 1);
    end else if (exp_q.size() == 0) begin
      checkOutput({tag, "_unexpected_result"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      last_plus = e[15:8];
      last_minus = e[7:0];
      checkOutput({tag, "_res_plus"}, 32'(res_plus), 32'(last_plus));
      checkOutput({tag, "_res_minus"}, 32'(res_minus), 32'(last_minus));
      checkOutput({tag, "_done_in_ready"}, 32'(in_ready), 0);
    end
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput({tag, "_idle_busy"}, 32'(busy), 0);
    checkOutput({tag, "_idle_res_valid"}, 32'(res_valid), 0);
  endtask

  initial begin
    tick();
    tick();
    checkIdleOutputs("reset");
    rst = 1'b0;

    // Single +1 digit gives one half; result must hold while unconsumed
    digs = '{1, 0, 0, 0, 0, 0, 0, 0};
    startRun(1'b1);
    applyStimulus(8, -1, 0, 1'b0);
    waitResult("run_a");
    repeat (3) tick();
    checkOutput("hold_res_valid", 32'(res_valid), 1);
    checkOutput("hold_res_plus", 32'(res_plus), 32'(last_plus));
    consume("run_a");

    // Stall after the 4th digit; zeros sent as {1,1}
    digs = '{1, -1, 0, 0, 0, 0, 0, 0};
    startRun(1'b0);
    applyStimulus(8, 4, 3, 1'b1);
    waitResult("run_b");
    consume("run_b");

    // Abort together with start and a valid 5th digit
    digs = '{1, 1, -1, 1, 1, 0, 0, 0};
    startRun(1'b0);
    applyStimulus(4, -1, 0, 1'b0);
    in_digit = encode(1, 1'b0);
    in_valid = 1'b1;
    abort = 1'b1;
    start = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    checkIdleOutputs("abort");
    digs = '{1, 0, 0, 0, 0, 0, 0, 0};
    startRun(1'b0);
    applyStimulus(8, -1, 0, 1'b0);
    waitResult("after_abort");

    // Back-to-back: consume and restart on the same edge
    res_ready = 1'b1;
    start = 1'b1;
    tick();
    res_ready = 1'b0;
    start = 1'b0;
    checkOutput("b2b_busy", 32'(busy), 1);
    checkOutput("b2b_in_ready", 32'(in_ready), 0);
    checkOutput("b2b_res_valid", 32'(res_valid), 0);
    checkOutput("b2b_res_plus", 32'(res_plus), 0);
    digs = '{0, 1, 1, -1, 0, 0, 1, 0};
    applyStimulus(8, -1, 0, 1'b0);
    waitResult("b2b");
    consume("b2b");

    // Reset mid-conversion discards the partial value
    digs = '{1, 1, 1, 0, 0, 0, 0, 0};
    startRun(1'b0);
    applyStimulus(3, -1, 0, 1'b0);
    rst = 1'b1;
    tick();
    checkIdleOutputs("mid_reset");
    rst = 1'b0;

    // start in DONE without res_ready is ignored
    digs = '{-1, 1, 1, 0, 1, 0, 0, 1};
    startRun(1'b0);
    applyStimulus(8, -1, 0, 1'b0);
    waitResult("run_e");
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("ignore_start_valid", 32'(res_valid), 1);
    checkOutput("ignore_start_plus", 32'(res_plus), 32'(last_plus));
    checkOutput("ignore_start_minus", 32'(res_minus), 32'(last_minus));
    consume("run_e");

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
